// File: rtl/lsu_pkg.sv
// Shared types and decode helpers for the load/store unit controller.
// Op flag vectors are ordered {lb, lh, lw, lbu, lhu, lwu, ld, sb, sh, sw, sd}.
package lsu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_WB,
        ST_ERR
    } state_t;

    typedef enum logic [1:0] {
        SZ_B,
        SZ_H,
        SZ_W,
        SZ_D
    } size_t;

    typedef enum logic [1:0] {
        ERR_NONE,
        ERR_ILL,
        ERR_MIS,
        ERR_BUS
    } err_t;

    localparam logic [7:0] BE_B = 8'h01;
    localparam logic [7:0] BE_H = 8'h03;
    localparam logic [7:0] BE_W = 8'h0F;
    localparam logic [7:0] BE_D = 8'hFF;

    localparam int unsigned TMO_DEFAULT = 255;

    typedef struct packed {
        size_t size;
        logic  sgn;
        logic  store;
    } op_info_t;

    function automatic op_info_t decode_op(input logic [10:0] f);
        op_info_t o;
        o.store = |f[3:0];
        o.sgn   = f[10] | f[9] | f[8];
        if (f[9] | f[6] | f[2])
            o.size = SZ_H;
        else if (f[8] | f[5] | f[1])
            o.size = SZ_W;
        else if (f[4] | f[0])
            o.size = SZ_D;
        else
            o.size = SZ_B;
        return o;
    endfunction

    function automatic logic is_onehot(input logic [10:0] f);
        return (f != 11'd0) && ((f & (f - 11'd1)) == 11'd0);
    endfunction

    function automatic logic is_misaligned(input size_t s, input logic [2:0] off);
        case (s)
            SZ_H:    return off[0];
            SZ_W:    return |off[1:0];
            SZ_D:    return |off;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering for the data port: byte enables, store-data replication and
// load-data extraction with sign/zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  size_t       i_size,
    input  logic        i_sgn,
    input  logic [2:0]  i_off,
    input  logic [63:0] i_rdata,
    input  logic [63:0] i_st_src,
    output logic [63:0] o_ld_data,
    output logic [63:0] o_st_data,
    output logic [7:0]  o_be
);

    logic [63:0] w_shift;
    logic [7:0]  w_mask;

    // NOTE: every output of a combinational block gets a default before the
    // case, so no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        w_shift   = i_rdata >> {i_off, 3'b000};
        o_ld_data = w_shift;
        o_st_data = i_st_src;
        w_mask    = BE_D;
        case (i_size)
            SZ_B: begin
                o_ld_data = {{56{i_sgn & w_shift[7]}}, w_shift[7:0]};
                o_st_data = {8{i_st_src[7:0]}};
                w_mask    = BE_B;
            end
            SZ_H: begin
                o_ld_data = {{48{i_sgn & w_shift[15]}}, w_shift[15:0]};
                o_st_data = {4{i_st_src[15:0]}};
                w_mask    = BE_H;
            end
            SZ_W: begin
                o_ld_data = {{32{i_sgn & w_shift[31]}}, w_shift[31:0]};
                o_st_data = {2{i_st_src[31:0]}};
                w_mask    = BE_W;
            end
            default: begin
                o_ld_data = w_shift;
                o_st_data = i_st_src;
                w_mask    = BE_D;
            end
        endcase
        o_be = w_mask << i_off;
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: accepts one decoded op, runs a single req/gnt/rvalid
// transaction on the data port and returns extended load data to writeback.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int          XLEN = 64,
    parameter int unsigned TMO  = TMO_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            dec_valid,
    output logic            dec_ready,
    input  logic            lb,
    input  logic            lh,
    input  logic            lw,
    input  logic            lbu,
    input  logic            lhu,
    input  logic            lwu,
    input  logic            ld,
    input  logic            sb,
    input  logic            sh,
    input  logic            sw,
    input  logic            sd,
    input  logic [4:0]      rd,
    input  logic [11:0]     imm,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [7:0]      mem_be,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            done,
    output logic            misalign,
    output logic            illegal,
    output logic            bus_err
);

    localparam logic [31:0] TMO_LIM = 32'(TMO);

    state_t          r_state;
    state_t          w_next;
    err_t            r_err;
    err_t            w_err_next;
    op_info_t        r_info;
    op_info_t        w_info;
    logic [4:0]      r_rd;
    logic [XLEN-1:0] r_ea;
    logic [XLEN-1:0] r_rs2;
    logic [XLEN-1:0] r_wb_data;
    logic [31:0]     r_cnt;
    logic            r_store_done;

    logic [10:0]     w_flags;
    logic [XLEN-1:0] w_ea;
    logic            w_accept;
    logic            w_timeout;
    logic [XLEN-1:0] w_ld_data;
    logic [XLEN-1:0] w_st_data;
    logic [7:0]      w_be;

    assign w_flags   = {lb, lh, lw, lbu, lhu, lwu, ld, sb, sh, sw, sd};
    assign w_info    = decode_op(w_flags);
    assign w_ea      = rs1_val + {{(XLEN-12){imm[11]}}, imm};
    assign w_accept  = (r_state == ST_IDLE) && dec_valid;
    // r_cnt holds completed REQ/WAIT cycles, so the TMO-th such cycle is the last one.
    assign w_timeout = (TMO_LIM != 32'd0) && (r_cnt == TMO_LIM - 32'd1);

    lsu_align u_align (
        .i_size    (r_info.size),
        .i_sgn     (r_info.sgn),
        .i_off     (r_ea[2:0]),
        .i_rdata   (mem_rdata),
        .i_st_src  (r_rs2),
        .o_ld_data (w_ld_data),
        .o_st_data (w_st_data),
        .o_be      (w_be)
    );

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_err        <= ERR_NONE;
            r_info       <= '{size: SZ_B, sgn: 1'b0, store: 1'b0};
            r_rd         <= '0;
            r_ea         <= '0;
            r_rs2        <= '0;
            r_wb_data    <= '0;
            r_cnt        <= '0;
            r_store_done <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_err        <= w_err_next;
            r_store_done <= (r_state == ST_REQ) && mem_gnt && r_info.store;
            if (w_accept) begin
                r_info <= w_info;
                r_rd   <= rd;
                r_ea   <= w_ea;
                r_rs2  <= rs2_val;
                r_cnt  <= '0;
            end else if ((r_state == ST_REQ) || (r_state == ST_WAIT)) begin
                r_cnt <= r_cnt + 32'd1;
            end
            if ((r_state == ST_WAIT) && mem_rvalid)
                r_wb_data <= w_ld_data;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_err_next = ERR_NONE;
        dec_ready  = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_be     = '0;
        mem_wdata  = '0;
        wb_valid   = 1'b0;
        wb_rd      = '0;
        wb_data    = '0;
        done       = r_store_done;
        misalign   = 1'b0;
        illegal    = 1'b0;
        bus_err    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                dec_ready = 1'b1;
                if (dec_valid) begin
                    if (!is_onehot(w_flags)) begin
                        w_next     = ST_ERR;
                        w_err_next = ERR_ILL;
                    end else if (is_misaligned(w_info.size, w_ea[2:0])) begin
                        w_next     = ST_ERR;
                        w_err_next = ERR_MIS;
                    end else begin
                        w_next = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                mem_req   = 1'b1;
                mem_we    = r_info.store;
                mem_addr  = {r_ea[XLEN-1:3], 3'b000};
                mem_be    = w_be;
                mem_wdata = w_st_data;
                // A grant in the final allowed cycle still completes the access.
                if (mem_gnt) begin
                    w_next = r_info.store ? ST_IDLE : ST_WAIT;
                end else if (w_timeout) begin
                    w_next     = ST_ERR;
                    w_err_next = ERR_BUS;
                end
            end
            ST_WAIT: begin
                if (mem_rvalid) begin
                    w_next = ST_WB;
                end else if (w_timeout) begin
                    w_next     = ST_ERR;
                    w_err_next = ERR_BUS;
                end
            end
            ST_WB: begin
                done     = 1'b1;
                wb_valid = (r_rd != 5'd0);
                wb_rd    = r_rd;
                wb_data  = r_wb_data;
                w_next   = ST_IDLE;
            end
            ST_ERR: begin
                illegal  = (r_err == ERR_ILL);
                misalign = (r_err == ERR_MIS);
                bus_err  = (r_err == ERR_BUS);
                w_next   = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: request/writeback expectations are queued when an
// op is issued and compared when the controller presents the matching output.
module tb_lsu_ctrl;

    localparam logic [10:0] F_LB  = 11'h400;
    localparam logic [10:0] F_LH  = 11'h200;
    localparam logic [10:0] F_LW  = 11'h100;
    localparam logic [10:0] F_LBU = 11'h080;
    localparam logic [10:0] F_LHU = 11'h040;
    localparam logic [10:0] F_LWU = 11'h020;
    localparam logic [10:0] F_LD  = 11'h010;
    localparam logic [10:0] F_SB  = 11'h008;
    localparam logic [10:0] F_SH  = 11'h004;
    localparam logic [10:0] F_SW  = 11'h002;
    localparam logic [10:0] F_SD  = 11'h001;

    localparam logic [212:0] OUT_IDLE = {1'b1, 212'b0};

    typedef struct packed {
        logic        we;
        logic [63:0] addr;
        logic [7:0]  be;
        logic [63:0] wdata;
    } req_t;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rd;
        logic [63:0] data;
    } wb_t;

    logic        clk, rst_n, dec_valid, dec_ready;
    logic [10:0] flags;
    logic [4:0]  rd, wb_rd;
    logic [11:0] imm;
    logic [63:0] rs1_val, rs2_val, mem_addr, mem_wdata, mem_rdata, wb_data;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid, wb_valid, done;
    logic        misalign, illegal, bus_err;
    logic [7:0]  mem_be;
    logic [212:0] w_outs;

    req_t exp_req_q[$];
    wb_t  exp_wb_q[$];
    int   n_pass = 0;
    int   n_total = 0;

    logic [7:0]  last_be;
    logic [63:0] last_addr, last_wdata, last_wb_data;
    int          last_req_cycles;

    lsu_ctrl #(.XLEN(64), .TMO(4)) dut (
        .clk(clk), .rst_n(rst_n), .dec_valid(dec_valid), .dec_ready(dec_ready),
        .lb(flags[10]), .lh(flags[9]), .lw(flags[8]), .lbu(flags[7]),
        .lhu(flags[6]), .lwu(flags[5]), .ld(flags[4]), .sb(flags[3]),
        .sh(flags[2]), .sw(flags[1]), .sd(flags[0]),
        .rd(rd), .imm(imm), .rs1_val(rs1_val), .rs2_val(rs2_val),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .done(done), .misalign(misalign), .illegal(illegal), .bus_err(bus_err)
    );

    assign w_outs = {dec_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
                     wb_valid, wb_rd, wb_data, done, misalign, illegal, bus_err};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic int nbytes(input logic [10:0] f);
        if ((f & (F_LB | F_LBU | F_SB)) != 11'd0) return 1;
        if ((f & (F_LH | F_LHU | F_SH)) != 11'd0) return 2;
        if ((f & (F_LW | F_LWU | F_SW)) != 11'd0) return 4;
        return 8;
    endfunction

    function automatic logic [63:0] calc_ea(input logic [63:0] base, input logic [11:0] off);
        logic [63:0] s;
        s = {{52{off[11]}}, off};
        return base + s;
    endfunction

    function automatic req_t model_req(input logic [10:0] f, input logic [63:0] ea,
                                       input logic [63:0] src);
        req_t r;
        int   n, o;
        n       = nbytes(f);
        o       = int'(ea[2:0]);
        r.we    = (f & (F_SB | F_SH | F_SW | F_SD)) != 11'd0;
        r.addr  = {ea[63:3], 3'b000};
        r.wdata = '0;
        for (int i = 0; i < 8; i++) begin
            r.be[i] = (i >= o) && (i < o + n);
            if (r.we) r.wdata[8*i +: 8] = src[8*(i % n) +: 8];
        end
        return r;
    endfunction

    function automatic logic [63:0] model_load(input logic [10:0] f, input logic [63:0] ea,
                                               input logic [63:0] dw);
        logic [63:0] v;
        int          n, o;
        n = nbytes(f);
        o = int'(ea[2:0]);
        v = '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = dw[8*(o+i) +: 8];
        if (((f & (F_LB | F_LH | F_LW)) != 11'd0) && v[8*n-1])
            for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
        return v;
    endfunction

    // Called at a negedge; presents the op for one cycle.
    task automatic send_op(input logic [10:0] f, input logic [4:0] r, input logic [11:0] i,
                           input logic [63:0] a, input logic [63:0] b);
        n_total++;
        if (dec_ready !== 1'b1) $display("FAIL accept_ready: dec_ready=%b required 1", dec_ready);
        else n_pass++;
        dec_valid = 1'b1; flags = f; rd = r; imm = i; rs1_val = a; rs2_val = b;
        @(negedge clk);
        dec_valid = 1'b0; flags = '0; rd = '0; imm = '0; rs1_val = '0; rs2_val = '0;
    endtask

    // Plays the memory side of one accepted op and checks it against the scoreboard.
    task automatic mem_txn(input int gnt_dly, input int rv_dly, input logic [63:0] dw);
        req_t er;
        wb_t  ew;
        logic [136:0] obs;
        er = exp_req_q.pop_front();
        last_req_cycles = 0;
        for (int k = 0; k <= gnt_dly; k++) begin
            obs = {mem_we, mem_addr, mem_be, er.we ? mem_wdata : 64'h0};
            n_total++;
            if ({mem_req, obs} !== {1'b1, er})
                $display("FAIL req_cycle%0d: got req=%b %h required req=1 %h", k, mem_req, obs, er);
            else n_pass++;
            if (mem_req === 1'b1) last_req_cycles++;
            if (k == 0) begin
                last_addr = mem_addr; last_be = mem_be; last_wdata = mem_wdata;
            end
            if (k == gnt_dly) mem_gnt = 1'b1;
            @(negedge clk);
            mem_gnt = 1'b0;
        end
        if (!er.we) begin
            n_total++;
            if ({mem_req, dec_ready, done} !== 3'b000)
                $display("FAIL wait_state: req/ready/done=%b required 000", {mem_req, dec_ready, done});
            else n_pass++;
            repeat (rv_dly) @(negedge clk);
            mem_rvalid = 1'b1; mem_rdata = dw;
            @(negedge clk);
            mem_rvalid = 1'b0; mem_rdata = '0;
            ew = exp_wb_q.pop_front();
            last_wb_data = wb_data;
            n_total++;
            if ({done, wb_valid, wb_rd, wb_data} !== {1'b1, ew})
                $display("FAIL writeback: got done=%b %b %0d %h required 1 %b %0d %h",
                         done, wb_valid, wb_rd, wb_data, ew.valid, ew.rd, ew.data);
            else n_pass++;
            @(negedge clk);
        end
        n_total++;
        if ({done, mem_req, dec_ready, wb_valid} !== {er.we, 3'b010})
            $display("FAIL completion: done/req/ready/wbv=%b required %b",
                     {done, mem_req, dec_ready, wb_valid}, {er.we, 3'b010});
        else n_pass++;
    endtask

    task automatic do_op(input logic [10:0] f, input logic [4:0] r, input logic [11:0] i,
                         input logic [63:0] a, input logic [63:0] b, input logic [63:0] dw,
                         input int gnt_dly, input int rv_dly);
        logic [63:0] ea;
        req_t        er;
        wb_t         ew;
        ea = calc_ea(a, i);
        er = model_req(f, ea, b);
        exp_req_q.push_back(er);
        if (!er.we) begin
            ew.valid = (r != 5'd0);
            ew.rd    = r;
            ew.data  = model_load(f, ea, dw);
            exp_wb_q.push_back(ew);
        end
        send_op(f, r, i, a, b);
        mem_txn(gnt_dly, rv_dly, dw);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; dec_valid = 1'b0; flags = '0; rd = '0; imm = '0;
        rs1_val = '0; rs2_val = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        repeat (3) @(negedge clk);
        n_total++;
        if (w_outs !== OUT_IDLE) $display("FAIL reset_outputs: got %h required %h", w_outs, OUT_IDLE);
        else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
        n_total++;
        if (w_outs !== OUT_IDLE) $display("FAIL post_reset_idle: got %h required %h", w_outs, OUT_IDLE);
        else n_pass++;
    endtask

    task automatic test_lw_negative_offset();
        do_op(F_LW, 5'd1, 12'hFFC, 64'h1000, 64'h0, 64'h8000_0000_0000_0000, 0, 0);
        n_total++;
        if ({last_addr, last_be, last_wb_data} !== {64'hFF8, 8'hF0, 64'hFFFF_FFFF_8000_0000})
            $display("FAIL lw_plan: addr=%h be=%h data=%h required FF8 F0 FFFFFFFF80000000",
                     last_addr, last_be, last_wb_data);
        else n_pass++;
    endtask

    task automatic test_lbu_top_byte();
        do_op(F_LBU, 5'd2, 12'h007, 64'h2000, 64'h0, 64'hAB00_0000_0000_0000, 0, 0);
        n_total++;
        if ({last_be, last_wb_data} !== {8'h80, 64'hAB})
            $display("FAIL lbu_plan: be=%h data=%h required 80 AB", last_be, last_wb_data);
        else n_pass++;
    endtask

    task automatic test_sh_delayed_gnt();
        do_op(F_SH, 5'd0, 12'h002, 64'h3000, 64'h1234, 64'h0, 3, 0);
        n_total++;
        if ({last_req_cycles, last_be, last_wdata} !== {32'd4, 8'h0C, 64'h1234_1234_1234_1234})
            $display("FAIL sh_plan: req_cycles=%0d be=%h wdata=%h required 4 0C 1234123412341234",
                     last_req_cycles, last_be, last_wdata);
        else n_pass++;
    endtask

    task automatic test_errors();
        send_op(F_LD, 5'd4, 12'h004, 64'h4000, 64'h0);
        n_total++;
        if ({misalign, illegal, bus_err, mem_req, dec_ready} !== 5'b10000)
            $display("FAIL misalign_pulse: mis/ill/bus/req/rdy=%b required 10000",
                     {misalign, illegal, bus_err, mem_req, dec_ready});
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (w_outs !== OUT_IDLE) $display("FAIL misalign_end: got %h required %h", w_outs, OUT_IDLE);
        else n_pass++;
        send_op(F_LB | F_SW, 5'd4, 12'h000, 64'h4000, 64'h0);
        n_total++;
        if ({misalign, illegal, bus_err, mem_req, dec_ready} !== 5'b01000)
            $display("FAIL illegal_pulse: mis/ill/bus/req/rdy=%b required 01000",
                     {misalign, illegal, bus_err, mem_req, dec_ready});
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (w_outs !== OUT_IDLE) $display("FAIL illegal_end: got %h required %h", w_outs, OUT_IDLE);
        else n_pass++;
    endtask

    task automatic test_timeout();
        req_t er;
        int   n;
        er = model_req(F_LW, 64'h5000, 64'h0);
        exp_req_q.push_back(er);
        send_op(F_LW, 5'd9, 12'h000, 64'h5000, 64'h0);
        er = exp_req_q.pop_front();
        n_total++;
        if ({mem_req, mem_we, mem_addr, mem_be} !== {1'b1, er.we, er.addr, er.be})
            $display("FAIL tmo_req: got %b %b %h %h required 1 %b %h %h",
                     mem_req, mem_we, mem_addr, mem_be, er.we, er.addr, er.be);
        else n_pass++;
        n = 0;
        while (mem_req === 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        n_total++;
        if (n != 4) $display("FAIL tmo_req_cycles: got %0d required 4", n);
        else n_pass++;
        n_total++;
        if ({misalign, illegal, bus_err, mem_req, dec_ready} !== 5'b00100)
            $display("FAIL bus_err_pulse: mis/ill/bus/req/rdy=%b required 00100",
                     {misalign, illegal, bus_err, mem_req, dec_ready});
        else n_pass++;
        @(negedge clk);
        mem_rvalid = 1'b1; mem_rdata = {$urandom, $urandom};
        @(negedge clk);
        mem_rvalid = 1'b0; mem_rdata = '0;
        n_total++;
        if (w_outs !== OUT_IDLE) $display("FAIL stray_rvalid: got %h required %h", w_outs, OUT_IDLE);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [10:0] ops [10] = '{F_LH, F_SB, F_LHU, F_SW, F_LWU, F_SD, F_LD, F_LB, F_SH, F_LW};
        logic [11:0] offs[10] = '{12'h006, 12'h005, 12'hFFE, 12'h7FC, 12'h004,
                                  12'hFF8, 12'h008, 12'h003, 12'h00E, 12'h000};
        for (int k = 0; k < 10; k++)
            do_op(ops[k], 5'(k + 5), offs[k], 64'h1000 * (k + 1), {$urandom, $urandom},
                  {$urandom, $urandom}, (k / 2) % 2, k % 2);
    endtask

    task automatic test_rd_zero();
        do_op(F_LB, 5'd0, 12'h001, 64'h6000, 64'h0, 64'h0000_0000_0000_8000, 0, 1);
    endtask

    task automatic test_reset_in_wait();
        req_t er;
        er = model_req(F_LW, 64'h7000, 64'h0);
        send_op(F_LW, 5'd3, 12'h000, 64'h7000, 64'h0);
        n_total++;
        if ({mem_req, mem_addr, mem_be} !== {1'b1, er.addr, er.be})
            $display("FAIL rst_req: got %b %h %h required 1 %h %h", mem_req, mem_addr, mem_be, er.addr, er.be);
        else n_pass++;
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        rst_n = 1'b0;
        #1;
        n_total++;
        if (w_outs !== OUT_IDLE) $display("FAIL reset_in_wait: got %h required %h", w_outs, OUT_IDLE);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 64'hDEAD_BEEF_0000_0001;
        @(negedge clk);
        mem_rvalid = 1'b0; mem_rdata = '0;
        @(negedge clk);
        n_total++;
        if (w_outs !== OUT_IDLE) $display("FAIL after_reset_release: got %h required %h", w_outs, OUT_IDLE);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_lw_negative_offset();
        test_lbu_top_byte();
        test_sh_delayed_gnt();
        test_errors();
        test_timeout();
        test_back_to_back();
        test_rd_zero();
        test_reset_in_wait();
        n_total++;
        if ((exp_req_q.size() + exp_wb_q.size()) != 0)
            $display("FAIL scoreboard_drain: %0d entries left required 0",
                     exp_req_q.size() + exp_wb_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
